// File: rtl/phone_number_pkg.sv
`default_nettype none
// ============================================================================
// Module   : phone_number_pkg
// Purpose  : Shared widths and default digit table for the phone number counter.
// Revision : 1.0  initial release
// ============================================================================
package phone_number_pkg;

   localparam int DIGIT_W            = 4;
   localparam int CNT_W              = 4;
   localparam int NUM_DIGITS_DEFAULT = 10;
   localparam int MAX_DIGITS         = 16;

   // Packed table, entry 0 in the least significant nibble.
   typedef logic [MAX_DIGITS-1:0][DIGIT_W-1:0] digit_tbl_t;

   // 9,8,4,8,0,2,2,3,3,8 from index 0 upward; unused entries are zero.
   localparam digit_tbl_t PHONE_DIGITS_DEFAULT = 64'h0000_0083_3220_8489;

endpackage : phone_number_pkg
`default_nettype wire

// File: rtl/phone_digit_rom.sv
`default_nettype none
// ============================================================================
// Module   : phone_digit_rom
// Purpose  : Combinational index-to-digit lookup table.
// Revision : 1.0  initial release
// ============================================================================
module phone_digit_rom
   import phone_number_pkg::*;
#(
   parameter int         DEPTH = NUM_DIGITS_DEFAULT,
   parameter digit_tbl_t TABLE = PHONE_DIGITS_DEFAULT
) (
   input  logic [CNT_W-1:0]   i_index,
   output logic [DIGIT_W-1:0] o_digit
);

   localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(DEPTH - 1);

   // Indices past the programmed depth never occur; return zero for them.
   always_comb begin
      o_digit = '0;
      if (i_index <= c_LAST_IDX) begin
         o_digit = TABLE[i_index];
      end
   end

endmodule : phone_digit_rom
`default_nettype wire

// File: rtl/phone_number_counter.sv
`default_nettype none
// ============================================================================
// Module   : phone_number_counter
// Purpose  : Free-running digit index with registered phone-number digit output.
// Revision : 1.0  initial release
// ============================================================================
module phone_number_counter
   import phone_number_pkg::*;
#(
   parameter int         NUM_DIGITS   = NUM_DIGITS_DEFAULT,
   parameter digit_tbl_t PHONE_DIGITS = PHONE_DIGITS_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   output logic [CNT_W-1:0]   count,
   output logic [DIGIT_W-1:0] number
);

   localparam logic [CNT_W-1:0]   c_LAST_IDX = CNT_W'(NUM_DIGITS - 1);
   localparam logic [DIGIT_W-1:0] c_DIGIT0   = PHONE_DIGITS[0];

   if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_depth
      $error("phone_number_counter: NUM_DIGITS must be in 2..16");
   end

   for (genvar gi = 0; gi < MAX_DIGITS; gi++) begin : g_chk_digit
      if (gi < NUM_DIGITS && PHONE_DIGITS[gi] > 4'd9) begin : g_bad_digit
         $error("phone_number_counter: PHONE_DIGITS entry exceeds 9");
      end
   end

   logic [CNT_W-1:0]   r_count;
   logic [DIGIT_W-1:0] r_number;
   logic [CNT_W-1:0]   w_count_next;
   logic [DIGIT_W-1:0] w_digit_next;

   always_comb begin
      w_count_next = r_count + 4'd1;
      if (r_count >= c_LAST_IDX) begin
         w_count_next = '0;
      end
   end

   // Looking up the next index keeps number aligned with count after the edge.
   phone_digit_rom #(
      .DEPTH (NUM_DIGITS),
      .TABLE (PHONE_DIGITS)
   ) u_rom (
      .i_index (w_count_next),
      .o_digit (w_digit_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count  <= '0;
         r_number <= c_DIGIT0;
      end else begin
         r_count  <= w_count_next;
         r_number <= w_digit_next;
      end
   end

   assign count  = r_count;
   assign number = r_number;

endmodule : phone_number_counter
`default_nettype wire

// File: tb/tb_phone_number_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_phone_number_counter
// Purpose  : Directed self-checking bench, default and 4-digit configurations.
// Revision : 1.0  initial release
// ============================================================================
module tb_phone_number_counter;

   logic       clk;
   logic       rst;
   logic [3:0] count;
   logic [3:0] number;
   logic [3:0] count4;
   logic [3:0] number4;

   int n_pass;
   int n_total;
   int idx10;
   int idx4;

   int exp_num10 [10] = '{9, 8, 4, 8, 0, 2, 2, 3, 3, 8};
   int exp_num4  [4]  = '{1, 2, 3, 4};
   int rel_cnt   [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
   int rel_num   [10] = '{8, 4, 8, 0, 2, 2, 3, 3, 8, 9};

   phone_number_counter u_dut (
      .clk    (clk),
      .rst    (rst),
      .count  (count),
      .number (number)
   );

   phone_number_counter #(
      .NUM_DIGITS   (4),
      .PHONE_DIGITS (64'h0000_0000_0000_4321)
   ) u_dut4 (
      .clk    (clk),
      .rst    (rst),
      .count  (count4),
      .number (number4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   // One clock: advance the reference index per the rst level seen at the edge,
   // then compare both instances at the falling edge.
   task automatic step();
      logic rst_at_edge;
      @(posedge clk);
      rst_at_edge = rst;
      @(negedge clk);
      if (rst_at_edge) begin
         idx10 = 0;
         idx4  = 0;
      end else begin
         idx10 = (idx10 == 9) ? 0 : idx10 + 1;
         idx4  = (idx4 == 3) ? 0 : idx4 + 1;
      end
      chk("cnt10", count, 4'(idx10));
      chk("num10", number, 4'(exp_num10[idx10]));
      chk("cnt10_range", 4'(count <= 4'd9), 4'd1);
      chk("cnt4", count4, 4'(idx4));
      chk("num4", number4, 4'(exp_num4[idx4]));
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      idx10   = 0;
      idx4    = 0;
      rst     = 1'b1;

      // 100 ns of reset
      for (int i = 0; i < 10; i++) begin
         step();
         chk("rst_cnt", count, 4'd0);
         chk("rst_num", number, 4'd9);
      end

      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("rel_cnt", count, 4'(rel_cnt[i]));
         chk("rel_num", number, 4'(rel_num[i]));
      end

      // Free-run to 1900 ns after release
      for (int i = 0; i < 180; i++) step();

      // Single-cycle reset at count 5
      for (int k = 0; k < 20 && count != 4'd5; k++) step();
      chk("reach5", count, 4'd5);
      rst = 1'b1;
      step();
      chk("rst5_cnt", count, 4'd0);
      chk("rst5_num", number, 4'd9);
      rst = 1'b0;
      step();
      chk("post5_cnt", count, 4'd1);
      chk("post5_num", number, 4'd8);

      // Three-cycle reset starting at count 9
      for (int k = 0; k < 20 && count != 4'd9; k++) step();
      chk("reach9", count, 4'd9);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst9_cnt", count, 4'd0);
         chk("rst9_num", number, 4'd9);
      end
      rst = 1'b0;
      step();
      chk("post9_cnt", count, 4'd1);
      chk("post9_num", number, 4'd8);

      for (int i = 0; i < 12; i++) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_phone_number_counter
`default_nettype wire
